// File: rtl/axi_firn.sv
// axi_firn: N-tap time-multiplexed FIR (one MAC per clock) with an AXI4-Lite register slave.
// Optional output saturation and sticky SAT flag: define AXI_FIRN_SAT_EN.
module axi_firn #(
  parameter int unsigned NTAPS                = 8,
  parameter int unsigned DW                   = 16,
  parameter int unsigned CW                   = 16,
  parameter int unsigned OUT_SHIFT            = 15,
  parameter int unsigned C_S00_AXI_ADDR_WIDTH = 5
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [31:0]                     s00_axi_wdata,
  input  logic [3:0]                      s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [31:0]                     s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic signed [DW-1:0]            s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic signed [DW-1:0]            m_data
);

  localparam int KW   = $clog2(NTAPS);
  localparam int AccW = DW + CW + $clog2(NTAPS);
  localparam int SW   = C_S00_AXI_ADDR_WIDTH - 2;

  localparam logic [SW-1:0] RegCtrl     = SW'(0);
  localparam logic [SW-1:0] RegStatus   = SW'(1);
  localparam logic [SW-1:0] RegIdx      = SW'(2);
  localparam logic [SW-1:0] RegCoefData = SW'(3);
  localparam logic [SW-1:0] RegLast     = SW'(4);

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  // AXI handshake state
  logic        r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]  r_bresp;
  logic [31:0] r_rdata;

  // Control registers and coefficient store
  logic                 r_en, r_clr_pend, r_sat;
  logic [7:0]           r_coef_idx;
  logic signed [CW-1:0] r_coef [NTAPS];

  // Datapath
  state_e                 r_state;
  logic [KW-1:0]          r_k;
  logic signed [AccW-1:0] r_acc;
  logic signed [DW-1:0]   r_x [NTAPS];
  logic                   r_m_valid;
  logic signed [DW-1:0]   r_m_data, r_last;
  logic [15:0]            r_cnt;

  logic                      w_wr, w_rd, w_accept, w_busy, w_idx_ok, w_coef_wr, w_wr_err;
  logic                      w_last, w_clip, w_sat_evt, w_clr_done, w_unused;
  logic [SW-1:0]             w_wsel, w_rsel;
  logic [31:0]               w_rdata, w_coef_rd;
  logic signed [CW-1:0]      w_coef_sel;
  logic signed [DW+CW-1:0]   w_prod;
  logic signed [AccW-1:0]    w_acc_sum, w_shifted;
  logic [DW-1:0]             w_out;

  assign w_wr      = r_awready & s00_axi_awvalid & s00_axi_wvalid;
  assign w_rd      = r_arready & s00_axi_arvalid;
  assign w_wsel    = s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2];
  assign w_rsel    = s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:2];
  assign s_ready   = r_en & ~r_m_valid & (r_state == StIdle) & ~r_clr_pend;
  assign w_accept  = s_valid & s_ready;
  assign w_busy    = (r_state != StIdle) | r_m_valid | w_accept;
  assign w_idx_ok  = 32'(r_coef_idx) < NTAPS;
  assign w_coef_sel = r_coef[r_coef_idx[KW-1:0]];
  assign w_coef_rd = w_idx_ok ? {{(32-CW){w_coef_sel[CW-1]}}, w_coef_sel} : 32'd0;
  assign w_coef_wr = w_wr & (w_wsel == RegCoefData);
  assign w_wr_err  = w_coef_wr & (~w_idx_ok | w_busy);
  assign w_clr_done = (r_state == StIdle) & r_clr_pend;
  assign w_unused  = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb, s00_axi_wdata,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0], w_shifted};

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_awready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = r_bresp;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = 2'b00;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_awready <= 1'b0;
      r_arready <= 1'b0;
      // ready pulses are withheld while a response is pending: one transaction in flight
      if (s00_axi_awvalid && s00_axi_wvalid && !r_awready && !r_bvalid) r_awready <= 1'b1;
      if (w_wr) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_err ? 2'b10 : 2'b00;
      end else if (r_bvalid && s00_axi_bready) begin
        r_bvalid <= 1'b0;
      end
      if (s00_axi_arvalid && !r_arready && !r_rvalid) r_arready <= 1'b1;
      if (w_rd) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end else if (r_rvalid && s00_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_rsel)
      RegCtrl:     w_rdata = {30'd0, r_clr_pend, r_en};
      RegStatus:   w_rdata = {r_cnt, 14'd0, r_sat, w_busy};
      RegIdx:      w_rdata = {24'd0, r_coef_idx};
      RegCoefData: w_rdata = w_coef_rd;
      RegLast:     w_rdata = {{(32-DW){r_last[DW-1]}}, r_last};
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_en       <= 1'b0;
      r_clr_pend <= 1'b0;
      r_sat      <= 1'b0;
      r_coef_idx <= '0;
      for (int i = 0; i < int'(NTAPS); i++) r_coef[i] <= '0;
    end else begin
      if (w_clr_done) r_clr_pend <= 1'b0;
      if (w_wr) begin
        case (w_wsel)
          RegCtrl: begin
            r_en <= s00_axi_wdata[0];
            if (s00_axi_wdata[1]) r_clr_pend <= 1'b1;
          end
          RegStatus: if (s00_axi_wdata[1]) r_sat <= 1'b0;
          RegIdx:    r_coef_idx <= s00_axi_wdata[7:0];
          RegCoefData: begin
            if (!w_wr_err) begin
              r_coef[r_coef_idx[KW-1:0]] <= s00_axi_wdata[CW-1:0];
              r_coef_idx <= r_coef_idx + 8'd1;
            end
          end
          default: ;
        endcase
      end
      // a fresh clip wins over a simultaneous W1C
      if (w_sat_evt) r_sat <= 1'b1;
    end
  end

  assign w_last    = r_k == KW'(NTAPS - 1);
  assign w_prod    = r_x[r_k] * r_coef[r_k];
  assign w_acc_sum = r_acc + AccW'(w_prod);
  assign w_shifted = w_acc_sum >>> OUT_SHIFT;
  assign w_sat_evt = (r_state == StMac) & w_last & w_clip;

`ifdef AXI_FIRN_SAT_EN
  localparam logic signed [AccW-1:0] OutMax = {{(AccW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AccW-1:0] OutMin = {{(AccW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  always_comb begin
    w_clip = 1'b0;
    w_out  = w_shifted[DW-1:0];
    if (w_shifted > OutMax) begin
      w_clip = 1'b1;
      w_out  = {1'b0, {(DW-1){1'b1}}};
    end else if (w_shifted < OutMin) begin
      w_clip = 1'b1;
      w_out  = {1'b1, {(DW-1){1'b0}}};
    end
  end
`else
  assign w_clip = 1'b0;
  assign w_out  = w_shifted[DW-1:0];
`endif

  // The final MAC edge also loads the output so m_valid lands NTAPS+1 cycles after accept
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state   <= StIdle;
      r_k       <= '0;
      r_acc     <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_last    <= '0;
      r_cnt     <= '0;
      for (int i = 0; i < int'(NTAPS); i++) r_x[i] <= '0;
    end else begin
      if (r_m_valid && m_ready) r_m_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (r_clr_pend) begin
            for (int i = 0; i < int'(NTAPS); i++) r_x[i] <= '0;
          end else if (w_accept) begin
            r_x[0] <= s_data;
            for (int i = 1; i < int'(NTAPS); i++) r_x[i] <= r_x[i-1];
            r_acc   <= '0;
            r_k     <= '0;
            r_state <= StMac;
          end
        end
        StMac: begin
          r_acc <= w_acc_sum;
          r_k   <= r_k + 1'b1;
          if (w_last) begin
            r_state   <= StOut;
            r_m_valid <= 1'b1;
            r_m_data  <= w_out;
            r_last    <= w_out;
            r_cnt     <= r_cnt + 16'd1;
          end
        end
        StOut:   r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/axi_firn.md
# axi_firn

Parametrised successor to the 8-tap AXI FIR: an N-tap, time-multiplexed FIR filter whose coefficients, control and status are held in an AXI4-Lite register slave (S00_AXI). Samples enter and leave on valid/ready streams, one multiply-accumulate per clock. It sits between the ADC capture path and the DAC/DMA sink, and is configured by the PS over the same AXI-Lite interconnect as the previous FIR.

## Interface
- NTAPS, 8: number of taps, 2..256.
- DW, 16: signed sample width, input and output.
- CW, 16: signed coefficient width.
- OUT_SHIFT, 15: arithmetic right shift applied to the accumulator before output.
- C_S00_AXI_ADDR_WIDTH, 5: AXI-Lite address width.
- s00_axi_aclk  in  1  single clock for everything.
- s00_axi_aresetn  in  1  asynchronous, active-low reset.
- s00_axi_aw*/w*/b*/ar*/r*  AXI4-Lite slave, 32-bit data; standard channel set, prot ignored.
- s_valid, s_ready, s_data  in/out/in  1/1/DW  input sample stream.
- m_valid, m_ready, m_data  out/in/out  1/1/DW  output sample stream.

## Operation
- Registers (word offsets):
  - 0x00 CTRL: bit0 EN; bit1 CLR (self-clearing, zeroes delay line).
  - 0x04 STATUS (RO, except bit1): bit0 BUSY; bit1 SAT sticky, W1C; [31:16] output count, wraps at 65535.
  - 0x08 COEF_IDX [7:0].
  - 0x0C COEF_DATA: write stores coef[COEF_IDX], then COEF_IDX += 1; read returns coef[COEF_IDX], no increment.
  - 0x10 LAST_OUT (RO): last m_data, sign-extended.
- Unmapped offsets: read 0, write ignored, OKAY response.
- COEF_IDX >= NTAPS: write ignored with SLVERR and no increment; read returns 0.
- COEF_DATA write while BUSY: SLVERR, no effect.
- FSM:
  - IDLE: s_ready = EN and !m_valid. On accept, shift s_data into delay line x[0], clear acc, k = 0, go MAC.
  - MAC: acc += x[k] * coef[k], k++; after k = NTAPS-1 go OUT.
  - OUT: m_data = sat/wrap(acc >>> OUT_SHIFT), m_valid = 1, go IDLE.
- m_valid is held until m_ready is sampled high. No new sample is accepted while m_valid = 1.
- Accumulator width is DW+CW+clog2(NTAPS) signed; it never overflows.
- CLR during MAC: the current computation completes with pre-clear data; the clear applies on return to IDLE.
- EN deasserted mid-computation: the computation finishes; only acceptance stops.

## Timing
- Reset values: all AXI valid outputs 0, bresp/rresp 0, s_ready 0, m_valid 0, m_data 0, and every register, coefficient and delay-line entry 0.
- AXI write: needs awvalid and wvalid together. awready/wready pulse for 1 cycle; bvalid follows the next cycle and is held until bready. Only one transaction is outstanding.
- AXI read: arready pulses 1 cycle; rvalid follows the next cycle and is held until rready.
- Sample latency: s_valid&s_ready at cycle t gives m_valid at cycle t+NTAPS+1.
- Maximum throughput is one sample per NTAPS+2 cycles with m_ready tied high.
- BUSY = 1 from the accept cycle until m_valid is released.
- Reset asserted mid-operation clears everything immediately; any pending bvalid/rvalid is dropped.

## Configuration
- AXI_FIRN_SAT_EN defined: output saturates to [-2^(DW-1), 2^(DW-1)-1] and STATUS.SAT is set on clip.
- AXI_FIRN_SAT_EN undefined: output is the low DW bits of the shifted accumulator (two's-complement wrap) and STATUS.SAT reads 0.

## Test plan
- Reset, then read 0x00–0x10 → all return 0; s_ready = 0, m_valid = 0.
- OUT_SHIFT=0. Write COEF_IDX=0, then COEF_DATA 1..8 → read back coef[3] (IDX=3) = 4. Read COEF_IDX after the loads = 8. A further COEF_DATA write → SLVERR.
- Coefficients 1..8, EN=1, impulse 1 followed by seven 0 samples → m_data = 1,2,...,8. Each m_valid arrives exactly NTAPS+1 cycles after its accept. Count field = 8.
- Backpressure: hold m_ready=0 for 20 cycles → m_data is stable, s_ready = 0, no sample is lost. On release, the next sample is accepted.
- Saturation with macro defined: all coefficients 0x7FFF, OUT_SHIFT=0, input 0x7FFF → m_data = 0x7FFF and SAT = 1. Writing 0x2 to STATUS → SAT = 0. Without the macro the same stimulus gives the wrapped low 16 bits and SAT = 0.
- Assert reset during MAC → m_valid = 0 within the reset, coefficients read 0 afterwards, and no m_valid appears after release.
